// File: rtl/lsu_mem_responder.sv
// rtl/lsu_mem_responder.sv - round-robin data-memory responder for LSU valid/ready ports
module lsu_mem_responder #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int LATENCY       = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           mem_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CONSUMERS-1:0]           mem_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CONSUMERS-1:0]           mem_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CONSUMERS-1:0]           mem_write_ready
);

  localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t                          state_q, state_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                gnt_q, gnt_d;
  logic                            op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0]            addr_q, addr_d;
  logic [DATA_BITS-1:0]            wdata_q, wdata_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [NUM_CONSUMERS-1:0]        rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0]        wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q;
  logic [DATA_BITS-1:0]            mem_q [DEPTH];

  logic [NUM_CONSUMERS-1:0]        pending;
  logic                            found;
  logic [PTR_W-1:0]                pick;
  logic                            do_read;
  logic                            do_write;

  assign pending         = mem_read_valid | mem_write_valid;
  assign mem_read_ready  = rd_ready_q;
  assign mem_write_ready = wr_ready_q;
  assign mem_read_data   = read_data_q;

  // Round-robin pick: first pending consumer scanning upward from rr_ptr.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] cand;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
      cand = PTR_W'(idx);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // FSM next state: grant in IDLE, count down in BUSY, wait for valid to drop in RELEASE.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    rd_ready_d = '0;
    wr_ready_d = '0;
    do_read    = 1'b0;
    do_write   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = pick;
          op_wr_d = mem_write_valid[pick];
          addr_d  = mem_write_valid[pick] ? mem_write_address[pick*ADDR_BITS +: ADDR_BITS]
                                          : mem_read_address[pick*ADDR_BITS +: ADDR_BITS];
          wdata_d = mem_write_data[pick*DATA_BITS +: DATA_BITS];
          count_d = CNT_W'(LATENCY - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          do_read  = !op_wr_q;
          do_write = op_wr_q;
          if (op_wr_q) wr_ready_d[gnt_q] = 1'b1;
          else         rd_ready_d[gnt_q] = 1'b1;
          rr_ptr_d = (gnt_q == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : gnt_q + 1'b1;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!(op_wr_q ? mem_write_valid[gnt_q] : mem_read_valid[gnt_q])) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Data memory and per-consumer read-data holding registers; reset wins over a pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      read_data_q <= '0;
    end else begin
      if (do_write) mem_q[addr_q] <= wdata_q;
      if (do_read)  read_data_q[gnt_q*DATA_BITS +: DATA_BITS] <= mem_q[addr_q];
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// tb/tb_lsu_mem_responder.sv - scoreboard bench for lsu_mem_responder
module tb_lsu_mem_responder;

  typedef struct packed {
    logic       wr;
    logic [1:0] cons;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  rv, wv;
  logic [7:0]  raddr [4];
  logic [7:0]  waddr [4];
  logic [7:0]  wdat  [4];
  logic [31:0] raddr_f, waddr_f, wdat_f;
  logic [3:0]  rd_ready, wr_ready;
  logic [31:0] rd_data;

  exp_t        sb [$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  rd_model [4];
  int          rd_hold [4];
  logic [3:0]  rd_hold_on;
  int          wr_pulses [4];
  int          last_ready_cyc [4];
  logic [3:0]  seen_rr, seen_wr;
  int          cyc;
  int          checks;
  int          errors;
  int          n;

  for (genvar g = 0; g < 4; g++) begin : g_flat
    assign raddr_f[g*8 +: 8] = raddr[g];
    assign waddr_f[g*8 +: 8] = waddr[g];
    assign wdat_f[g*8 +: 8]  = wdat[g];
  end

  lsu_mem_responder #(
    .NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(8), .LATENCY(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_valid   (rv),
    .mem_read_address (raddr_f),
    .mem_read_ready   (rd_ready),
    .mem_read_data    (rd_data),
    .mem_write_valid  (wv),
    .mem_write_address(waddr_f),
    .mem_write_data   (wdat_f),
    .mem_write_ready  (wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_read(input int c, input logic [7:0] a);
    exp_t e;
    e.wr = 1'b0; e.cons = 2'(c); e.data = ref_mem[a];
    sb.push_back(e);
    raddr[c] = a;
    rv[c] = 1'b1;
  endtask

  task automatic push_write(input int c, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.wr = 1'b1; e.cons = 2'(c); e.data = d;
    sb.push_back(e);
    ref_mem[a] = d;
    waddr[c] = a;
    wdat[c] = d;
    wv[c] = 1'b1;
  endtask

  // One clock: sample at negedge, score any ready pulse, then act as the LSUs.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    seen_rr = rd_ready;
    seen_wr = wr_ready;
    check("ready_onehot", 32'($countones({seen_rr, seen_wr}) <= 1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (seen_wr[i]) wr_pulses[i]++;
      if (seen_rr[i] || seen_wr[i]) begin
        last_ready_cyc[i] = cyc;
        if (sb.size() == 0) begin
          check("unexpected_ready", {24'd0, seen_wr, seen_rr}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ready_consumer", 32'(i), 32'(e.cons));
          check("ready_is_write", 32'(seen_wr[i]), 32'(e.wr));
          if (!e.wr) rd_model[i] = e.data;
          for (int j = 0; j < 4; j++)
            check($sformatf("read_data[%0d]", j), 32'(rd_data[j*8 +: 8]), 32'(rd_model[j]));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (rd_hold_on[i]) begin
        rd_hold[i]--;
        if (rd_hold[i] == 0) begin
          rv[i] = 1'b0;
          rd_hold_on[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (seen_rr[i]) begin
        if (rd_hold[i] > 0) rd_hold_on[i] = 1'b1;
        else rv[i] = 1'b0;
      end
      if (seen_wr[i]) wv[i] = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      cycle();
      k++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    cycle();
    cycle();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; n = 0;
    rv = '0; wv = '0; rd_hold_on = '0;
    seen_rr = '0; seen_wr = '0;
    for (int i = 0; i < 4; i++) begin
      raddr[i] = '0; waddr[i] = '0; wdat[i] = '0;
      rd_model[i] = '0; rd_hold[i] = 0; wr_pulses[i] = 0; last_ready_cyc[i] = 0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // Reset state
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_read_ready", 32'(rd_ready), 32'd0);
    check("rst_write_ready", 32'(wr_ready), 32'd0);
    check("rst_read_data", rd_data, 32'd0);

    // Read latency: preload 0x10 then read it from consumer 0
    push_write(0, 8'h10, 8'h5A);
    wait_done();
    push_read(0, 8'h10);
    cycle(); check("lat_cycle1", 32'(seen_rr), 32'd0);
    cycle(); check("lat_cycle2", 32'(seen_rr), 32'd0);
    cycle(); check("lat_cycle3", 32'(seen_rr), 32'd1);
    cycle(); check("lat_pulse_end", 32'(seen_rr), 32'd0);
    wait_done();

    // Write then read the last word from consumer 1; neighbouring word stays 0
    n = wr_pulses[1];
    push_write(1, 8'hFF, 8'hC3);
    wait_done();
    check("wr1_pulse_count", 32'(wr_pulses[1] - n), 32'd1);
    push_read(1, 8'hFF);
    wait_done();
    push_read(3, 8'hFE);
    wait_done();

    // Round-robin: all four read together, expected order 0,1,2,3
    push_read(0, 8'h10);
    push_read(1, 8'hFF);
    push_read(2, 8'h20);
    push_read(3, 8'h30);
    wait_done();

    // Consumer 0 re-requests after being served while 1 and 2 still pending
    push_read(0, 8'h10);
    push_read(1, 8'hFF);
    push_read(2, 8'h20);
    n = 0;
    while (sb.size() > 2 && n < 100) begin
      cycle();
      n++;
    end
    check("rr_first_served", 32'(sb.size()), 32'd2);
    cycle();
    push_read(0, 8'hFF);
    wait_done();

    // Same consumer with write and read valid: write served first
    push_write(2, 8'h20, 8'h77);
    push_read(2, 8'h20);
    wait_done();

    // Held read valid on consumer 3 blocks the next grant until it drops
    rd_hold[3] = 3;
    push_read(3, 8'h10);
    push_read(0, 8'h20);
    wait_done();
    check("held_gap", 32'(last_ready_cyc[0] - last_ready_cyc[3]), 32'd7);

    // Reset one cycle after a write grant aborts the write
    waddr[1] = 8'h40; wdat[1] = 8'hAB; wv[1] = 1'b1;
    cycle();
    reset = 1'b1;
    wv[1] = 1'b0;
    cycle();
    reset = 1'b0;
    repeat (4) cycle();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < 4; i++) rd_model[i] = '0;
    check("midrst_read_data", rd_data, 32'd0);
    check("midrst_ready", 32'({rd_ready, wr_ready}), 32'd0);
    push_read(0, 8'h40);
    push_read(2, 8'h10);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
